// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU share arbiter: FSM encoding,
// flag bit positions inside resp_flags, and the default datapath width.
package alu_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester handshakes plus the shared ALU connection.
// The slave modport is the arbiter's view; master is the clients/ALU view.
interface alu_share_arbiter_if import alu_arb_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_sel, req1_sel;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;

  logic             resp0_valid, resp1_valid;
  logic             resp0_ready, resp1_ready;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_n, alu_v, alu_z, alu_c;

  modport slave (
    input  req0_valid, req1_valid, req0_sel, req1_sel,
           req0_a, req0_b, req1_a, req1_b,
           resp0_ready, resp1_ready,
           alu_result, alu_n, alu_v, alu_z, alu_c,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_result, resp_flags, alu_a, alu_b, alu_sel
  );

  modport master (
    output req0_valid, req1_valid, req0_sel, req1_sel,
           req0_a, req0_b, req1_a, req1_b,
           resp0_ready, resp1_ready,
           alu_result, alu_n, alu_v, alu_z, alu_c,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_result, resp_flags, alu_a, alu_b, alu_sel
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that did not win last time. Purely combinational, one-hot out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: grant, drive the
// registered operands for one cycle, capture the result, hand it back.
module alu_share_arbiter import alu_arb_pkg::*; (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);

  logic [1:0] state, state_nxt;
  logic [1:0] grant_vec;
  logic       last_grant;
  logic       grant_q;
  logic       resp_taken;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant_vec)
  );

  assign resp_taken = grant_q ? bus.resp1_ready : bus.resp0_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vec != 2'b00) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is masked during reset so nothing is accepted on a reset edge.
  always_comb begin
    bus.req0_ready  = (state == IDLE) && grant_vec[0] && !rst;
    bus.req1_ready  = (state == IDLE) && grant_vec[1] && !rst;
    bus.resp0_valid = (state == RESP) && !grant_q;
    bus.resp1_valid = (state == RESP) &&  grant_q;
  end

  // NOTE: every datapath register has an explicit reset value, so a reset mid-op leaves no stale result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_sel     <= 3'b000;
      bus.resp_result <= '0;
      bus.resp_flags  <= 4'b0000;
      grant_q         <= 1'b0;
      last_grant      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vec != 2'b00) begin
            bus.alu_a   <= grant_vec[1] ? bus.req1_a   : bus.req0_a;
            bus.alu_b   <= grant_vec[1] ? bus.req1_b   : bus.req0_b;
            bus.alu_sel <= grant_vec[1] ? bus.req1_sel : bus.req0_sel;
            grant_q     <= grant_vec[1];
            last_grant  <= grant_vec[1];
          end
        end
        EXEC: begin
          bus.resp_result        <= bus.alu_result;
          bus.resp_flags[FLAG_N] <= bus.alu_n;
          bus.resp_flags[FLAG_V] <= bus.alu_v;
          bus.resp_flags[FLAG_Z] <= bus.alu_z;
          bus.resp_flags[FLAG_C] <= bus.alu_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational 8-bit ALU (A, B, 3-bit Select in; Result and N/V/C/Z flags out) between two requesters. Grants are round-robin and issued through valid/ready handshakes. The block latches the granted operands, drives them onto the ALU, captures Result and flags one cycle later, and returns them to the granted requester under a response handshake. It sits between the ALU instance and the two client blocks that previously drove the ALU directly.

## Interface
- WIDTH, 8, operand/result width; must match the ALU instance
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i has an operation pending
- req0_ready / req1_ready  out  1  one-cycle accept strobe to requester i
- req0_sel / req1_sel  in  3  ALU Select code, passed through unmodified
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- resp0_valid / resp1_valid  out  1  response available for requester i
- resp0_ready / resp1_ready  in  1  requester i consumes response
- resp_result  out  WIDTH  captured ALU Result, shared by both requesters
- resp_flags  out  4  captured flags, bit order {N,V,Z,C} (bit3..bit0)
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_sel  out  3  to ALU Select
- alu_result  in  WIDTH  from ALU Result
- alu_n, alu_v, alu_z, alu_c  in  1  from ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP; encoded 2'b00, 2'b01, 2'b10. 2'b11 is illegal and returns to IDLE on the next edge.
- **IDLE**:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: assert reqN_ready combinationally for that cycle; on the edge, load alu_a/alu_b/alu_sel from the granted port, record grant and last_grant, and go to EXEC.
- **EXEC**:
  - ALU settles combinationally from the registered alu_* outputs.
  - On the edge, capture resp_result ← alu_result and resp_flags ← {alu_n,alu_v,alu_z,alu_c}, then go to RESP.
- **RESP**:
  - respN_valid is high for the granted requester only.
  - When respN_ready is high, go to IDLE on that edge.
  - resp_result and resp_flags hold until the next EXEC capture.
- Requesters hold valid, sel and operands stable until ready is seen. The arbiter samples them only in the ready cycle.
- No second grant is issued while in EXEC or RESP. The other requester waits; its valid may stay high.
- A non-granted requester's resp*_valid stays 0 throughout.
- Select semantics are opaque to the block; no opcode decoding is done.

## Timing
- Reset values:
  - State IDLE.
  - last_grant = 1, so requester 0 wins the first contention.
  - req*_ready = 0, resp*_valid = 0.
  - resp_result = 0, resp_flags = 4'b0000.
  - alu_a = 0, alu_b = 0, alu_sel = 3'b000.
- Latency:
  - Accept (ready high) in cycle t.
  - resp_valid is high from cycle t+2.
  - Minimum issue interval is 3 cycles, reached when resp_ready is held high.
- Response handshake: resp_valid stays high until consumed; a stalled resp_ready stalls all further grants.
- Simultaneous valid: exactly one ready is high in any cycle; both readys are never high together.
- Alternation: both requesters held valid alternate grants 0,1,0,1,…
- Reset asserted mid-operation (EXEC or RESP):
  - The in-flight op is discarded with no response.
  - All outputs return to reset values on that edge.
  - The requester must not treat the op as completed.
- req valid dropping outside a ready cycle is legal and has no effect.

## Structure
- Package alu_arb_pkg holds:
  - state encoding localparams IDLE/EXEC/RESP
  - flag bit indices FLAG_N=3, FLAG_V=2, FLAG_Z=1, FLAG_C=0
  - default WIDTH
- One sub-module: rr_arb2. It is combinational: inputs req[1:0] and last_grant; outputs a one-hot grant[1:0].
- The FSM, operand registers and response registers are in the top module.

## Test plan
The bench ALU stub returns A+B on sel 3'b000 and A&B on sel 3'b001, with flags computed per the team ALU.

1. Reset, no requests -> all outputs 0 for 10 cycles.
2. Only req0 valid, sel=000, A=8'h05, B=8'h03:
   - req0_ready high 1 cycle.
   - resp0_valid two cycles later with result 8'h08, flags 4'b0000.
   - resp1_valid never asserted.
3. req0 and req1 valid in the same cycle (req0: 000, 8'h7F, 8'h01; req1: 001, 8'hF0, 8'h3C):
   - req0 granted first; resp_result 8'h80 with N=1, V=1.
   - Then req1 granted; result 8'h30, flags 0000.
4. Both valid continuously for 6 ops with resp*_ready tied high:
   - Grant order 0,1,0,1,0,1.
   - One accept every 3 cycles.
5. resp0_ready held low 5 cycles with req1 valid:
   - resp0_valid and resp_result stable throughout.
   - req1_ready stays 0 until the cycle after resp0_ready rises.
6. rst pulsed during EXEC:
   - No resp_valid for that op; outputs return to reset values.
   - Next contention grants req0.
